// File: rtl/lc_ctrl_pkg.sv
// Life cycle controller shared types: transition token index matrix, lc_tx_t
// multibit boolean and the sparse state encoding of the token-check FSM.
package lc_ctrl_pkg;

    localparam int NumDecLcStates  = 21;
    localparam int DecLcStateWidth = 5;
    localparam int TokenIdxWidth   = 3;
    localparam int NumTokens       = 2 ** TokenIdxWidth;
    localparam int TokenWidth      = 128;

    localparam int RawIdx      = 0;
    localparam int LastTestIdx = 15;
    localparam int DevIdx      = 16;
    localparam int ProdIdx     = 17;
    localparam int ProdEndIdx  = 18;
    localparam int RmaIdx      = 19;
    localparam int ScrapIdx    = 20;

    typedef enum logic [3:0] {
        On  = 4'b0101,
        Off = 4'b1010
    } lc_tx_t;

    typedef enum logic [TokenIdxWidth-1:0] {
        ZeroTokenIdx       = 3'd0,
        RawUnlockTokenIdx  = 3'd1,
        TestUnlockTokenIdx = 3'd2,
        TestExitTokenIdx   = 3'd3,
        RmaTokenIdx        = 3'd4,
        InvalidTokenIdx    = 3'd5
    } token_idx_e;

    typedef logic [NumTokens-1:0][TokenWidth-1:0] lc_token_mux_t;

    // Codewords of a shortened [6,3,3] Hamming code: any single or double
    // bit flip lands on an unused code.
    localparam int TokChkStateWidth = 6;
    typedef enum logic [TokChkStateWidth-1:0] {
        IdleSt   = 6'b001011,
        LookupSt = 6'b010101,
        HashSt   = 6'b011110,
        Check0St = 6'b100110,
        Check1St = 6'b101101,
        DoneSt   = 6'b110011,
        ErrorSt  = 6'b111000
    } tok_chk_state_e;

    typedef logic [NumDecLcStates-1:0][NumDecLcStates-1:0][TokenIdxWidth-1:0] trans_matrix_t;

    // Test states alternate TEST_UNLOCKEDn (odd) / TEST_LOCKEDn (even); the
    // level n of either is (idx-1)/2.
    function automatic token_idx_e trans_token_idx(input int cur, input int tgt);
        token_idx_e idx;
        int         cur_lvl;
        int         tgt_lvl;
        logic       cur_unlocked;
        logic       cur_locked;
        logic       tgt_unlocked;
        logic       tgt_locked;
        logic       tgt_exit;
        cur_unlocked = (cur >= 1) && (cur <= LastTestIdx) && ((cur % 2) == 1);
        cur_locked   = (cur >= 2) && (cur <= LastTestIdx) && ((cur % 2) == 0);
        tgt_unlocked = (tgt >= 1) && (tgt <= LastTestIdx) && ((tgt % 2) == 1);
        tgt_locked   = (tgt >= 2) && (tgt <= LastTestIdx) && ((tgt % 2) == 0);
        tgt_exit     = (tgt == DevIdx) || (tgt == ProdIdx) || (tgt == ProdEndIdx);
        cur_lvl      = (cur - 1) / 2;
        tgt_lvl      = (tgt - 1) / 2;
        idx          = InvalidTokenIdx;
        if (tgt == ScrapIdx) begin
            if (cur != ScrapIdx) idx = ZeroTokenIdx;
        end else if (cur == RawIdx) begin
            if (tgt_unlocked) idx = RawUnlockTokenIdx;
        end else if (cur_unlocked) begin
            if (tgt_locked && tgt_lvl >= cur_lvl)        idx = ZeroTokenIdx;
            else if (tgt_unlocked && tgt_lvl > cur_lvl)  idx = TestUnlockTokenIdx;
            else if (tgt_exit)                           idx = TestExitTokenIdx;
            else if (tgt == RmaIdx)                      idx = RmaTokenIdx;
        end else if (cur_locked) begin
            if (tgt_unlocked && tgt_lvl > cur_lvl)       idx = TestUnlockTokenIdx;
            else if (tgt_exit)                           idx = TestExitTokenIdx;
        end else if ((cur == DevIdx || cur == ProdIdx) && tgt == RmaIdx) begin
            idx = RmaTokenIdx;
        end
        return idx;
    endfunction

    function automatic trans_matrix_t gen_trans_matrix();
        trans_matrix_t m;
        for (int c = 0; c < NumDecLcStates; c++) begin
            for (int t = 0; t < NumDecLcStates; t++) begin
                m[c][t] = trans_token_idx(c, t);
            end
        end
        return m;
    endfunction

    localparam trans_matrix_t TransTokenIdxMatrix = gen_trans_matrix();

endpackage

// File: rtl/lc_ctrl_token_lookup.sv
// Combinational transition lookup: range check, matrix index and selection of
// one hashed-token slice, either by the matrix result or by a held index.
module lc_ctrl_token_lookup
    import lc_ctrl_pkg::*;
#(
    parameter int NumLcStates  = 21,
    parameter int LcTokenWidth = 128
) (
    input  logic [DecLcStateWidth-1:0]        cur_idx,
    input  logic [DecLcStateWidth-1:0]        tgt_idx,
    input  logic                              use_reg_idx,
    input  logic [TokenIdxWidth-1:0]          reg_token_idx,
    input  logic [NumTokens*LcTokenWidth-1:0] token_mux,
    output logic                              trans_invalid,
    output logic [TokenIdxWidth-1:0]          token_idx,
    output logic [LcTokenWidth-1:0]           token
);

    logic [LcTokenWidth-1:0]  slices [NumTokens];
    logic                     in_range;
    logic [TokenIdxWidth-1:0] slice_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NumTokens; gi++) begin : g_slice
            assign slices[gi] = token_mux[gi*LcTokenWidth +: LcTokenWidth];
        end
    endgenerate

    // The matrix is only NumDecLcStates wide, so guard against a larger
    // NumLcStates as well as out-of-range requests.
    assign in_range = (int'(cur_idx) < NumLcStates) && (int'(tgt_idx) < NumLcStates) &&
                      (int'(cur_idx) < NumDecLcStates) && (int'(tgt_idx) < NumDecLcStates);

    always_comb begin
        token_idx = InvalidTokenIdx;
        if (in_range) begin
            token_idx = TransTokenIdxMatrix[cur_idx][tgt_idx];
        end
    end

    assign trans_invalid = (token_idx == InvalidTokenIdx);
    assign slice_idx     = use_reg_idx ? reg_token_idx : token_idx;
    assign token         = slices[slice_idx];

endmodule

// File: rtl/lc_ctrl_token_check.sv
// Transition-token checker: looks up the required token, fetches the hashed
// user token over req/ack and compares it twice before issuing an lc_tx_t verdict.
module lc_ctrl_token_check
    import lc_ctrl_pkg::*;
#(
    parameter int NumLcStates       = 21,
    parameter int LcTokenWidth      = 128,
    parameter int HashTimeoutCycles = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_i,
    input  logic [4:0]                        cur_state_idx_i,
    input  logic [4:0]                        trans_target_idx_i,
    input  logic [NumTokens*LcTokenWidth-1:0] token_mux_i,
    output logic                              hash_req_o,
    input  logic                              hash_ack_i,
    input  logic [LcTokenWidth-1:0]           hashed_token_i,
    output logic                              busy_o,
    output logic                              done_o,
    output lc_tx_t                            ok_o,
    output logic                              trans_invalid_error_o,
    output logic                              token_error_o,
    output logic                              state_error_o
);

    localparam int CntWidth = $clog2(HashTimeoutCycles);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(HashTimeoutCycles - 1);

    tok_chk_state_e           state_reg, state_next;
    logic [4:0]               cur_idx_reg, cur_idx_next;
    logic [4:0]               tgt_idx_reg, tgt_idx_next;
    logic [TokenIdxWidth-1:0] token_idx_reg, token_idx_next;
    logic [LcTokenWidth-1:0]  expected_reg, expected_next;
    logic [LcTokenWidth-1:0]  hashed_reg, hashed_next;
    logic [CntWidth-1:0]      cnt_reg, cnt_next;
    lc_tx_t                   ok_reg, ok_next;
    logic                     trans_inv_reg, trans_inv_next;
    logic                     tok_err_reg, tok_err_next;
    logic                     state_err_reg, state_err_next;

    logic                     lookup_invalid;
    logic [TokenIdxWidth-1:0] lookup_idx;
    logic [LcTokenWidth-1:0]  lookup_token;

    // In Check1 the same lookup re-slices the live constants with the held index.
    lc_ctrl_token_lookup #(
        .NumLcStates  (NumLcStates),
        .LcTokenWidth (LcTokenWidth)
    ) u_lookup (
        .cur_idx       (cur_idx_reg),
        .tgt_idx       (tgt_idx_reg),
        .use_reg_idx   (state_reg == Check1St),
        .reg_token_idx (token_idx_reg),
        .token_mux     (token_mux_i),
        .trans_invalid (lookup_invalid),
        .token_idx     (lookup_idx),
        .token         (lookup_token)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IdleSt;
            cur_idx_reg   <= '0;
            tgt_idx_reg   <= '0;
            token_idx_reg <= '0;
            expected_reg  <= '0;
            hashed_reg    <= '0;
            cnt_reg       <= '0;
            ok_reg        <= Off;
            trans_inv_reg <= 1'b0;
            tok_err_reg   <= 1'b0;
            state_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_idx_reg   <= cur_idx_next;
            tgt_idx_reg   <= tgt_idx_next;
            token_idx_reg <= token_idx_next;
            expected_reg  <= expected_next;
            hashed_reg    <= hashed_next;
            cnt_reg       <= cnt_next;
            ok_reg        <= ok_next;
            trans_inv_reg <= trans_inv_next;
            tok_err_reg   <= tok_err_next;
            state_err_reg <= state_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cur_idx_next   = cur_idx_reg;
        tgt_idx_next   = tgt_idx_reg;
        token_idx_next = token_idx_reg;
        expected_next  = expected_reg;
        hashed_next    = hashed_reg;
        cnt_next       = cnt_reg;
        ok_next        = ok_reg;
        trans_inv_next = trans_inv_reg;
        tok_err_next   = tok_err_reg;
        state_err_next = state_err_reg;
        hash_req_o     = 1'b0;
        done_o         = 1'b0;
        busy_o         = 1'b1;

        unique case (state_reg)
            IdleSt: begin
                busy_o = 1'b0;
                if (req_i) begin
                    cur_idx_next   = cur_state_idx_i;
                    tgt_idx_next   = trans_target_idx_i;
                    ok_next        = Off;
                    trans_inv_next = 1'b0;
                    tok_err_next   = 1'b0;
                    state_next     = LookupSt;
                end
            end
            LookupSt: begin
                if (lookup_invalid) begin
                    trans_inv_next = 1'b1;
                    state_next     = DoneSt;
                end else begin
                    token_idx_next = lookup_idx;
                    expected_next  = lookup_token;
                    cnt_next       = '0;
                    state_next     = HashSt;
                end
            end
            HashSt: begin
                hash_req_o = 1'b1;
                // An ack arriving on the last allowed cycle still counts.
                if (hash_ack_i) begin
                    hashed_next = hashed_token_i;
                    state_next  = Check0St;
                end else if (cnt_reg == CntMax) begin
                    tok_err_next = 1'b1;
                    state_next   = DoneSt;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            Check0St: begin
                if (hashed_reg != expected_reg) begin
                    tok_err_next = 1'b1;
                    state_next   = DoneSt;
                end else begin
                    state_next = Check1St;
                end
            end
            Check1St: begin
                if (hashed_reg == lookup_token) begin
                    ok_next = On;
                end else begin
                    tok_err_next = 1'b1;
                end
                state_next = DoneSt;
            end
            DoneSt: begin
                done_o     = 1'b1;
                state_next = IdleSt;
            end
            ErrorSt: begin
                busy_o         = 1'b0;
                ok_next        = Off;
                state_err_next = 1'b1;
            end
            default: begin
                busy_o         = 1'b0;
                ok_next        = Off;
                state_err_next = 1'b1;
                state_next     = ErrorSt;
            end
        endcase
    end

    assign ok_o                  = ok_reg;
    assign trans_invalid_error_o = trans_inv_reg;
    assign token_error_o         = tok_err_reg;
    assign state_error_o         = state_err_reg;

endmodule

// File: tb/tb_lc_ctrl_token_check.sv
// Randomized self-checking bench for lc_ctrl_token_check against a rule-level
// model of the transition table and the handshake/verdict timing.
module tb_lc_ctrl_token_check;
    import lc_ctrl_pkg::*;

    localparam int T  = 16;
    localparam int W  = 128;
    localparam int NT = 8;
    localparam logic [3:0] ON_V  = 4'b0101;
    localparam logic [3:0] OFF_V = 4'b1010;
    localparam int ZERO = 0, RAWU = 1, TESTU = 2, TESTX = 3, RMA = 4, INV = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [4:0]    cur;
    logic [4:0]    tgt;
    logic [NT*W-1:0] mux;
    logic          hreq;
    logic          ack;
    logic [W-1:0]  htok;
    logic          busy;
    logic          done;
    logic [3:0]    ok;
    logic          inv;
    logic          terr;
    logic          serr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lc_ctrl_token_check #(
        .NumLcStates       (21),
        .LcTokenWidth      (W),
        .HashTimeoutCycles (T)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .req_i                 (req),
        .cur_state_idx_i       (cur),
        .trans_target_idx_i    (tgt),
        .token_mux_i           (mux),
        .hash_req_o            (hreq),
        .hash_ack_i            (ack),
        .hashed_token_i        (htok),
        .busy_o                (busy),
        .done_o                (done),
        .ok_o                  (ok),
        .trans_invalid_error_o (inv),
        .token_error_o         (terr),
        .state_error_o         (serr)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d fails=%0d", n_checks, n_fail);
        $fatal(1);
    end

    // Required token for a transition, stated as life cycle rules on indices:
    // 0 RAW, 1..15 alternating TEST_UNLOCKED/TEST_LOCKED, 16 DEV, 17 PROD,
    // 18 PROD_END, 19 RMA, 20 SCRAP.
    function automatic int model_tok(input int c, input int t);
        bit c_test, c_unlocked;
        if (c > 20 || t > 20) return INV;
        if (t == 20) return (c == 20) ? INV : ZERO;
        if (c == 0) return (t >= 1 && t <= 15 && t % 2 == 1) ? RAWU : INV;
        c_test     = (c >= 1 && c <= 15);
        c_unlocked = (c % 2 == 1);
        if (c_test) begin
            if (t >= 1 && t <= 15 && t > c) begin
                if (t % 2 == 1) return TESTU;
                return c_unlocked ? ZERO : INV;
            end
            if (t >= 16 && t <= 18) return TESTX;
            if (t == 19 && c_unlocked) return RMA;
            return INV;
        end
        if ((c == 16 || c == 17) && t == 19) return RMA;
        return INV;
    endfunction

    task automatic rand_mux();
        for (int s = 0; s < NT; s++) mux[s*W +: W] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Drives one request (cycle 0 = req high) and records what the DUT did.
    // Entered and left at a falling edge with the DUT idle.
    task automatic do_txn(input int c, input int t, input int ack_at, input logic [W-1:0] ack_val,
                          input int glitch_slice, output int done_at, output int hreq_n,
                          output int hreq_first, output int hreq_last, output logic [3:0] ok_v,
                          output logic inv_v, output logic terr_v, output logic done_low_after);
        logic [NT*W-1:0] saved;
        saved = mux;
        done_at = -1; hreq_n = 0; hreq_first = -1; hreq_last = -1;
        ok_v = 4'b0; inv_v = 1'b0; terr_v = 1'b0;
        for (int rel = 0; rel < T + 12; rel++) begin
            if (hreq === 1'b1) begin
                hreq_n++;
                if (hreq_first < 0) hreq_first = rel;
                hreq_last = rel;
            end
            if (done === 1'b1) begin
                done_at = rel; ok_v = ok; inv_v = inv; terr_v = terr;
                break;
            end
            req  = (rel == 0);
            cur  = 5'(c);
            tgt  = 5'(t);
            ack  = (rel == ack_at);
            htok = (rel == ack_at) ? ack_val : {$urandom(), $urandom(), $urandom(), $urandom()};
            mux  = saved;
            if (glitch_slice >= 0 && ack_at >= 0 && rel == ack_at + 2)
                mux[glitch_slice*W +: W] = ~saved[glitch_slice*W +: W];
            @(negedge clk);
        end
        req = 1'b0; ack = 1'b0; mux = saved;
        @(negedge clk);
        done_low_after = (done === 1'b0);
        $display("txn cur=%0d tgt=%0d ack@%0d glitch=%0d -> done@%0d hreq=%0d ok=%b inv=%b terr=%b",
                 c, t, ack_at, glitch_slice, done_at, hreq_n, ok_v, inv_v, terr_v);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; ack = 1'b0; cur = '0; tgt = '0; htok = '0;
        rand_mux();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ok !== OFF_V) begin n_fail++; $display("FAIL reset_ok: got %b expected %b", ok, OFF_V); end
        n_checks++; if ({hreq, busy, done, inv, terr, serr} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {hreq, busy, done, inv, terr, serr});
        end
    endtask

    task automatic test_valid_raw();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        rand_mux();
        mux[1*W +: W] = {16{8'hA5}};
        do_txn(0, 1, 4, {16{8'hA5}}, -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (d !== 7) begin n_fail++; $display("FAIL raw_done_cycle: got %0d expected 7", d); end
        n_checks++; if (hf !== 2 || hl !== 4 || hn !== 3) begin
            n_fail++; $display("FAIL raw_hash_req: got first=%0d last=%0d n=%0d expected 2 4 3", hf, hl, hn);
        end
        n_checks++; if (okv !== ON_V) begin n_fail++; $display("FAIL raw_ok: got %b expected %b", okv, ON_V); end
        n_checks++; if (iv !== 1'b0 || tv !== 1'b0) begin n_fail++; $display("FAIL raw_errors: got inv=%b terr=%b expected 0 0", iv, tv); end
        n_checks++; if (dl !== 1'b1) begin n_fail++; $display("FAIL raw_done_pulse: done still high after one cycle"); end
    endtask

    task automatic test_invalid();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        int pairs [2][2] = '{'{0, 0}, '{21, 0}};
        for (int p = 0; p < 2; p++) begin
            do_txn(pairs[p][0], pairs[p][1], 3, '0, -1, d, hn, hf, hl, okv, iv, tv, dl);
            n_checks++; if (d !== 2) begin n_fail++; $display("FAIL inv_done_cycle[%0d]: got %0d expected 2", p, d); end
            n_checks++; if (hn !== 0) begin n_fail++; $display("FAIL inv_hash_req[%0d]: got %0d cycles expected 0", p, hn); end
            n_checks++; if (iv !== 1'b1 || tv !== 1'b0 || okv !== OFF_V) begin
                n_fail++; $display("FAIL inv_verdict[%0d]: got inv=%b terr=%b ok=%b expected 1 0 %b", p, iv, tv, okv, OFF_V);
            end
        end
    endtask

    task automatic test_mismatch();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        logic [W-1:0] s4;
        rand_mux();
        s4 = mux[4*W +: W];
        do_txn(17, 19, 5, s4 ^ W'(1), -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (tv !== 1'b1 || okv !== OFF_V || iv !== 1'b0 || d !== 7) begin
            n_fail++; $display("FAIL mismatch_bit0: got terr=%b ok=%b inv=%b done@%0d expected 1 %b 0 7", tv, okv, iv, d, OFF_V);
        end
        do_txn(17, 19, 5, s4, 4, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (tv !== 1'b1 || okv !== OFF_V || d !== 8) begin
            n_fail++; $display("FAIL mismatch_check1_glitch: got terr=%b ok=%b done@%0d expected 1 %b 8", tv, okv, d, OFF_V);
        end
    endtask

    task automatic test_timeout();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        rand_mux();
        do_txn(16, 19, -1, '0, -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (d !== 2 + T || hn !== T) begin
            n_fail++; $display("FAIL timeout_cycle: got done@%0d hreq=%0d expected %0d %0d", d, hn, 2 + T, T);
        end
        n_checks++; if (tv !== 1'b1 || okv !== OFF_V) begin
            n_fail++; $display("FAIL timeout_verdict: got terr=%b ok=%b expected 1 %b", tv, okv, OFF_V);
        end
        do_txn(16, 19, T + 1, mux[4*W +: W], -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (tv !== 1'b0 || okv !== ON_V || d !== T + 4) begin
            n_fail++; $display("FAIL ack_on_timeout_cycle: got terr=%b ok=%b done@%0d expected 0 %b %0d", tv, okv, d, ON_V, T + 4);
        end
    endtask

    task automatic test_zero_token();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        rand_mux();
        mux[0 +: W] = '0;
        do_txn(1, 2, 3, '0, -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (okv !== ON_V || hn !== 2 || d !== 6) begin
            n_fail++; $display("FAIL zero_token: got ok=%b hreq=%0d done@%0d expected %b 2 6", okv, hn, d, ON_V);
        end
    endtask

    task automatic test_random();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        int c, t, idx, ack_at, glitch, e_done, e_hreq;
        logic [3:0] e_ok; logic e_inv, e_terr, match;
        logic [W-1:0] slice, ack_val;
        for (int n = 0; n < 40; n++) begin
            rand_mux();
            c = $urandom_range(0, 20);
            t = $urandom_range(0, 20);
            if ($urandom_range(0, 9) == 0) c = $urandom_range(21, 31);
            else for (int k = 0; k < 8 && model_tok(c, t) == INV; k++) t = $urandom_range(0, 20);
            idx     = model_tok(c, t);
            ack_at  = ($urandom_range(0, 6) == 0) ? -1 : $urandom_range(2, T + 1);
            slice   = mux[idx*W +: W];
            match   = ($urandom_range(0, 3) != 0);
            ack_val = match ? slice : slice ^ (W'(1) << $urandom_range(0, W - 1));
            glitch  = (idx != INV && match && $urandom_range(0, 4) == 0) ? idx : -1;
            e_ok = OFF_V; e_inv = 1'b0; e_terr = 1'b0;
            if (idx == INV) begin
                e_done = 2; e_hreq = 0; e_inv = 1'b1;
            end else if (ack_at < 0) begin
                e_done = 2 + T; e_hreq = T; e_terr = 1'b1;
            end else begin
                e_hreq = ack_at - 1;
                if (!match) begin e_done = ack_at + 2; e_terr = 1'b1; end
                else if (glitch >= 0) begin e_done = ack_at + 3; e_terr = 1'b1; end
                else begin e_done = ack_at + 3; e_ok = ON_V; end
            end
            do_txn(c, t, ack_at, ack_val, glitch, d, hn, hf, hl, okv, iv, tv, dl);
            n_checks++; if (d !== e_done || hn !== e_hreq || dl !== 1'b1) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got done@%0d hreq=%0d pulse_ok=%b expected %0d %0d 1", n, d, hn, dl, e_done, e_hreq);
            end
            n_checks++; if (okv !== e_ok || iv !== e_inv || tv !== e_terr) begin
                n_fail++; $display("FAIL rand_verdict[%0d]: got ok=%b inv=%b terr=%b expected %b %b %b", n, okv, iv, tv, e_ok, e_inv, e_terr);
            end
        end
    endtask

    task automatic test_reset_mid();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        rand_mux();
        req = 1'b1; cur = 5'd0; tgt = 5'd1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (hreq !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: got hreq=%b busy=%b expected 1 1", hreq, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (hreq !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ok !== OFF_V) begin
            n_fail++; $display("FAIL midreset_async: got hreq=%b busy=%b done=%b ok=%b expected 0 0 0 %b", hreq, busy, done, ok, OFF_V);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        do_txn(0, 1, 6, mux[1*W +: W], -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (okv !== ON_V || d !== 9) begin
            n_fail++; $display("FAIL midreset_after: got ok=%b done@%0d expected %b 9", okv, d, ON_V);
        end
    endtask

    task automatic test_state_fault();
        int d, hn, hf, hl; logic [3:0] okv; logic iv, tv, dl;
        logic any_activity;
        rand_mux();
        do_txn(0, 3, 3, mux[1*W +: W], -1, d, hn, hf, hl, okv, iv, tv, dl);
        n_checks++; if (ok !== ON_V) begin n_fail++; $display("FAIL fault_pre_ok: got %b expected %b", ok, ON_V); end
        force dut.state_reg = tok_chk_state_e'(6'b000000);
        @(posedge clk); #1;
        release dut.state_reg;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (serr !== 1'b1 || ok !== OFF_V || busy !== 1'b0 || hreq !== 1'b0) begin
            n_fail++; $display("FAIL fault_enter: got serr=%b ok=%b busy=%b hreq=%b expected 1 %b 0 0", serr, ok, busy, hreq, OFF_V);
        end
        req = 1'b1; cur = 5'd0; tgt = 5'd1;
        any_activity = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); req = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0 || hreq !== 1'b0 || serr !== 1'b1) any_activity = 1'b1;
        end
        n_checks++; if (any_activity !== 1'b0) begin
            n_fail++; $display("FAIL fault_sticky: got activity=%b serr=%b expected 0 1", any_activity, serr);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_checks++; if (serr !== 1'b0 || ok !== OFF_V) begin
            n_fail++; $display("FAIL fault_cleared_by_reset: got serr=%b ok=%b expected 0 %b", serr, ok, OFF_V);
        end
    endtask

    initial begin
        test_reset();
        test_valid_raw();
        test_invalid();
        test_mismatch();
        test_timeout();
        test_zero_token();
        test_random();
        test_reset_mid();
        test_state_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
